// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU: FSM states,
// adder slice width and the add/subtract opcode values.
package alu_nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_nibble_seq_if.sv
// CPU-bus side of the nibble-serial ALU: operand loads, op request and
// the registered result/flag/operand readback.
interface alu_nibble_seq_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] bus_in;
  logic              load_a;
  logic              load_b;
  logic              start;
  logic              sub;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry_flag;
  logic              zero_flag;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  modport master (
    output bus_in, load_a, load_b, start, sub,
    input  busy, done, result, carry_flag, zero_flag, a_out, b_out
  );

  modport slave (
    input  bus_in, load_a, load_b, start, sub,
    output busy, done, result, carry_flag, zero_flag, a_out, b_out
  );
endinterface

// File: rtl/alu_nibble_seq_adder.sv
// N-bit ripple-carry adder shared by both nibbles of the sequencer.
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C0,
  output logic [N-1:0] S,
  output logic         CN
);

  logic carry;

  // Carry is rippled through a blocking variable so the chain stays inside one process.
  always_comb begin
    S     = '0;
    carry = C0;
    for (int i = 0; i < N; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    CN = carry;
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// 8-bit add/subtract built from one 4-bit adder run over two cycles
// (low nibble, then high nibble), with operand and result/flag registers.
module alu_nibble_seq #(
  parameter int DATA_W   = 8,
  parameter int NIBBLE_W = alu_nibble_seq_pkg::NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  alu_nibble_seq_if.slave  bus
);
  import alu_nibble_seq_pkg::*;

  generate
    if (DATA_W != 2 * NIBBLE_W) begin : g_bad_width
      $error("alu_nibble_seq: DATA_W must equal 2*NIBBLE_W");
    end
  endgenerate

  state_e state_q, state_d;

  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   result_q;
  logic                carry_q;
  logic                carry_flag_q;
  logic                zero_flag_q;
  logic                sub_q;
  logic                accept_start;

  logic [NIBBLE_W-1:0] add_a;
  logic [NIBBLE_W-1:0] add_b;
  logic [NIBBLE_W-1:0] add_s;
  logic                add_c0;
  logic                add_cn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = LO;
          accept_start = 1'b1;
        end
      end
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert the B slice, and inject the +1 as the low-nibble carry-in.
  always_comb begin
    add_a  = a_q[NIBBLE_W-1:0];
    add_b  = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
    add_c0 = (sub_q == OP_SUB);
    if (state_q == HI) begin
      add_a  = a_q[DATA_W-1:NIBBLE_W];
      add_b  = b_q[DATA_W-1:NIBBLE_W] ^ {NIBBLE_W{sub_q}};
      add_c0 = carry_q;
    end
  end

  adder #(
    .N (NIBBLE_W)
  ) u_adder (
    .A  (add_a),
    .B  (add_b),
    .C0 (add_c0),
    .S  (add_s),
    .CN (add_cn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      sub_q        <= OP_ADD;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_a) a_q <= bus.bus_in;
          if (bus.load_b) b_q <= bus.bus_in;
          if (accept_start) sub_q <= bus.sub;
        end
        LO: begin
          result_q[NIBBLE_W-1:0] <= add_s;
          carry_q                <= add_cn;
        end
        HI: begin
          result_q[DATA_W-1:NIBBLE_W] <= add_s;
          carry_flag_q                <= add_cn;
          zero_flag_q                 <= ({add_s, result_q[NIBBLE_W-1:0]} == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q == LO) || (state_q == HI);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.carry_flag = carry_flag_q;
  assign bus.zero_flag  = zero_flag_q;
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alu_nibble_seq;

  logic clk;
  logic rst;

  alu_nibble_seq_if #(.DATA_W(8)) bus ();

  alu_nibble_seq #(
    .DATA_W   (8),
    .NIBBLE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Behavioural model: phase counts cycles since the accepted start (0 = idle).
  int         m_phase = 0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, p_res = '0;
  logic       m_c = 1'b0, m_z = 1'b0, p_c = 1'b0, p_z = 1'b0;
  int         ai, bi;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_a = '0; m_b = '0; m_res = '0; m_c = 1'b0; m_z = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.load_a) m_a = bus.bus_in;
          if (bus.load_b) m_b = bus.bus_in;
          if (bus.start) begin
            ai = int'(m_a);
            bi = int'(m_b);
            if (bus.sub) begin
              p_res = 8'(ai - bi);
              p_c   = (ai >= bi);
            end else begin
              p_res = 8'(ai + bi);
              p_c   = (ai + bi) > 255;
            end
            p_z     = (p_res == 8'h00);
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          m_res = p_res; m_c = p_c; m_z = p_z;
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, (m_phase == 1) || (m_phase == 2));
    check("done", bus.done, (m_phase == 3));
    check("a_out", bus.a_out, m_a);
    check("b_out", bus.b_out, m_b);
    if (m_phase == 0 || m_phase == 3) begin
      check("result", bus.result, m_res);
      check("carry_flag", bus.carry_flag, m_c);
      check("zero_flag", bus.zero_flag, m_z);
    end
  end

  task automatic idle_inputs();
    bus.bus_in = '0; bus.load_a = 1'b0; bus.load_b = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic la, input logic lb,
                       input logic st, input logic sb);
    bus.bus_in = d; bus.load_a = la; bus.load_b = lb;
    bus.start = st; bus.sub = sb;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end
  endtask

  task automatic expect_op(input string name, input logic [7:0] r, input logic c, input logic z);
    check({name, "_result"}, bus.result, r);
    check({name, "_carry"}, bus.carry_flag, c);
    check({name, "_zero"}, bus.zero_flag, z);
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sb, input logic [7:0] r, input logic c, input logic z);
    drive(a, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(b, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, sb);
    idle_inputs();
    wait_done(name);
    expect_op(name, r, c, z);
    @(negedge clk);
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 8'h00);
    check("rst_a", bus.a_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Low-nibble carry propagation, with explicit two-cycle busy window
    drive(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    check("t1_busy_lo", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_busy_hi", bus.busy, 1'b1);
    check("t1_done_early", bus.done, 1'b0);
    @(negedge clk);
    check("t1_done", bus.done, 1'b1);
    check("t1_busy_done", bus.busy, 1'b0);
    expect_op("t1", 8'h41, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_done_pulse", bus.done, 1'b0);

    run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("t3a", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op("t3b", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);

    // Start and load_a during LO must both be ignored
    drive(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(8'h99, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    wait_done("t4");
    expect_op("t4", 8'h46, 1'b0, 1'b0);
    check("t4_a_kept", bus.a_out, 8'h12);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("t4_extra_done", done_cnt, 0);

    // Reset during HI aborts the operation
    drive(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    @(negedge clk);
    check("t5_busy_hi", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", bus.busy, 1'b0);
    check("t5_done", bus.done, 1'b0);
    check("t5_a", bus.a_out, 8'h00);
    check("t5_b", bus.b_out, 8'h00);
    expect_op("t5", 8'h00, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("t5_no_done", done_cnt, 0);

    // Same-cycle load and start, then a start in the cycle right after done
    drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_inputs();
    wait_done("t6a");
    expect_op("t6a", 8'h08, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    check("t6b_accepted", bus.busy, 1'b1);
    wait_done("t6b");
    expect_op("t6b", 8'hFA, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    rst = 1'b0;
    idle_inputs();
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
